vit213_sync_ctrl: RTL
=====================

# vit213_sync_ctrl

Resynchronization controller for the (2,1,3) Viterbi decoder. It consumes the per-symbol out-of-sync error flag and decides whether the decoder is locked. It counts errors over fixed symbol windows. On loss of sync or a software request it slips the received bit-pair phase by one channel bit, clears the path metrics, and waits a settling period before re-acquiring.

## Interface
- WINDOW, 32: symbols per evaluation window (2..63)
- LOCK_THRESH, 2: max errors per window to declare lock from ACQ
- LOSS_THRESH, 6: min errors per window to declare loss from LOCK
- SETTLE_LEN, 16: symbols ignored after a slip (1..63)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- sym_valid  in  1  decoder accepted one symbol pair this cycle
- sync_err  in  1  out-of-sync flag from the error detector; qualified by sym_valid
- force_resync  in  1  one-cycle software resync request
- slip  out  1  one-cycle pulse; input deserializer drops one channel bit
- metric_clear  out  1  one-cycle pulse; clears path metric memory and stage counter
- phase  out  1  current bit-pair phase, toggles on each slip
- locked  out  1  high while in LOCK
- slip_count  out  4  slips since reset, saturating at 15
- state  out  2  ACQ=00, LOCK=01, SLIP=10, SETTLE=11

## Operation
- Reset value of every output is 0: state=ACQ, phase=0, slip_count=0, locked=0, slip=0, metric_clear=0. Internal win_cnt and err_cnt are also 0.
- win_cnt (6b) increments on sym_valid. err_cnt (6b) increments on sym_valid&&sync_err and saturates at 63. sync_err without sym_valid is ignored.
- Window end occurs on a sym_valid cycle with win_cnt==WINDOW-1. At that point errs = err_cnt + (sync_err?1:0) is evaluated, and both counters clear.
- ACQ: counters run. At window end, errs<=LOCK_THRESH goes to LOCK; otherwise the state goes to SLIP.
- LOCK: counters run. At window end, errs>=LOSS_THRESH goes to SLIP; otherwise the state stays in LOCK with counters cleared. Errors between the two thresholds hold lock (hysteresis).
- SLIP: lasts one cycle. slip=1, metric_clear=1, phase toggles, slip_count increments (saturating), counters clear. The next state is always SETTLE.
- SETTLE: win_cnt counts sym_valid and sync_err is ignored. On the sym_valid with win_cnt==SETTLE_LEN-1, the state goes to ACQ with counters cleared.
- force_resync in ACQ, LOCK or SETTLE goes to SLIP next cycle. It has priority over window evaluation in the same cycle. force_resync while in SLIP is ignored.
- locked = (state==LOCK). slip = metric_clear = (state==SLIP). All outputs are registered or decoded directly from registered state, with no combinational input-to-output path.
- Reset asserted mid-operation returns everything to reset values immediately, including phase=0.

## Timing
- Window-end sym_valid at cycle N gives the new state at N+1. locked rises or falls at N+1.
- Loss path: the window end at N puts SLIP at N+1 (slip and metric_clear high for exactly that cycle, phase toggled at N+2 edge visible) and SETTLE at N+2.
- force_resync sampled at N gives slip=1 at N+1.
- phase and slip_count change on the edge ending the SLIP cycle, so they are visible at N+2.
- Minimum re-acquire time after a slip is 1 + SETTLE_LEN + WINDOW symbol periods.
- Back-to-back slips require at least SETTLE_LEN+WINDOW sym_valid cycles between them, unless force_resync is used.

## Test plan
- Reset, then 32 sym_valid with zero errors: locked=1 the cycle after the 32nd symbol, state=01, slip_count=0.
- From LOCK, one window with 6 errors: slip and metric_clear high for one cycle, then phase=1, slip_count=1, state=11. After 16 symbols state=00. After 32 clean symbols locked=1.
- From LOCK, a window with 5 errors: stays locked. A window with 6 errors, including an error on the final symbol: slip occurs.
- In ACQ, a window with 3 errors: slip occurs. Repeat 17 times: slip_count saturates at 15 and phase alternates every slip.
- force_resync in the same cycle as a clean window end in ACQ: state=SLIP, not LOCK. force_resync during SLIP: exactly one slip pulse.
- sync_err=1 with sym_valid=0 for 100 cycles: no count and no state change. Reset asserted in SETTLE: all outputs read 0 the same cycle.

Source files
------------

// File: rtl/vit213_sync_ctrl_if.sv
// Handshake bundle between the Viterbi decoder datapath and its resync controller.
interface vit213_sync_ctrl_if;
    logic       sym_valid;
    logic       sync_err;
    logic       force_resync;
    logic       slip;
    logic       metric_clear;
    logic       phase;
    logic       locked;
    logic [3:0] slip_count;
    logic [1:0] state;

    modport master (
        output sym_valid, sync_err, force_resync,
        input  slip, metric_clear, phase, locked, slip_count, state
    );

    modport slave (
        input  sym_valid, sync_err, force_resync,
        output slip, metric_clear, phase, locked, slip_count, state
    );
endinterface

// File: rtl/vit213_sync_ctrl.sv
// Lock detector and bit-pair phase slipper for the (2,1,3) Viterbi decoder.
module vit213_sync_ctrl #(
    parameter int WINDOW      = 32,
    parameter int LOCK_THRESH = 2,
    parameter int LOSS_THRESH = 6,
    parameter int SETTLE_LEN  = 16
) (
    input  logic               clock,
    input  logic               reset,
    vit213_sync_ctrl_if.slave  bus
);
    localparam logic [1:0] ACQ    = 2'b00;
    localparam logic [1:0] LOCK   = 2'b01;
    localparam logic [1:0] SLIP   = 2'b10;
    localparam logic [1:0] SETTLE = 2'b11;

    logic [1:0] state_q;
    logic [5:0] win_cnt;
    logic [5:0] err_cnt;
    logic       phase_q;
    logic [3:0] slips_q;
    logic       win_end;
    logic       settle_end;
    logic [6:0] errs;

    assign win_end    = bus.sym_valid && (win_cnt == 6'(WINDOW - 1));
    assign settle_end = bus.sym_valid && (win_cnt == 6'(SETTLE_LEN - 1));
    // Includes the error flag of the window's final symbol
    assign errs       = {1'b0, err_cnt} + {6'd0, bus.sync_err};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ACQ;
            win_cnt <= '0;
            err_cnt <= '0;
            phase_q <= 1'b0;
            slips_q <= '0;
        end else begin
            unique case (state_q)
                ACQ, LOCK: begin
                    if (bus.force_resync) begin
                        state_q <= SLIP;
                        win_cnt <= '0;
                        err_cnt <= '0;
                    end else if (win_end) begin
                        win_cnt <= '0;
                        err_cnt <= '0;
                        if (state_q == ACQ)
                            state_q <= (errs <= 7'(LOCK_THRESH)) ? LOCK : SLIP;
                        else
                            state_q <= (errs >= 7'(LOSS_THRESH)) ? SLIP : LOCK;
                    end else if (bus.sym_valid) begin
                        win_cnt <= win_cnt + 6'd1;
                        if (bus.sync_err && err_cnt != 6'd63)
                            err_cnt <= err_cnt + 6'd1;
                    end
                end
                SLIP: begin
                    state_q <= SETTLE;
                    phase_q <= ~phase_q;
                    win_cnt <= '0;
                    err_cnt <= '0;
                    if (slips_q != 4'd15)
                        slips_q <= slips_q + 4'd1;
                end
                SETTLE: begin
                    if (bus.force_resync) begin
                        state_q <= SLIP;
                        win_cnt <= '0;
                        err_cnt <= '0;
                    end else if (settle_end) begin
                        state_q <= ACQ;
                        win_cnt <= '0;
                        err_cnt <= '0;
                    end else if (bus.sym_valid) begin
                        win_cnt <= win_cnt + 6'd1;
                    end
                end
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.locked       = (state_q == LOCK);
    assign bus.slip         = (state_q == SLIP);
    assign bus.metric_clear = (state_q == SLIP);
    assign bus.phase        = phase_q;
    assign bus.slip_count   = slips_q;
endmodule
